// File: rtl/icache_assoc.sv
// Set-associative instruction cache: true-LRU replacement, multi-word blocks filled from word 0, whole-cache flush.
// Optional hit/miss performance counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_assoc #(
  parameter int unsigned SETS          = 8,
  parameter int unsigned WAYS          = 2,
  parameter int unsigned WORDS_PER_BLK = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        flushing,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int unsigned OBITS = $clog2(WORDS_PER_BLK);
  localparam int unsigned WB    = (OBITS > 0) ? OBITS : 1;
  localparam int unsigned IB    = $clog2(SETS);
  localparam int unsigned TW    = 30 - OBITS - IB;
  localparam int unsigned AB    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t state_q, state_d;

  logic          valid_q [SETS][WAYS];
  logic [TW-1:0] tag_q   [SETS][WAYS];
  logic [AB-1:0] age_q   [SETS][WAYS];
  logic [31:0]   data_q  [SETS][WAYS][WORDS_PER_BLK];

  logic [TW-1:0] req_tag, miss_tag_q;
  logic [IB-1:0] req_idx, miss_idx_q, fcnt_q, touch_set;
  logic [WB-1:0] req_off, wcnt_q;
  logic [AB-1:0] hit_way, victim_d, victim_q, touch_way;
  logic          hit_any, fill_last, miss_start, touch_en, flush_pending_q;
  logic          addr_unused;

  assign req_tag     = imemaddr[31 -: TW];
  assign req_idx     = imemaddr[2 + OBITS +: IB];
  assign req_off     = WB'((imemaddr >> 2) & 32'(WORDS_PER_BLK - 1));
  assign addr_unused = ^imemaddr[1:0];

  // Lookup: first matching valid way wins (ways never alias within a set).
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = AB'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    logic found;
    found    = 1'b0;
    victim_d = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        found    = 1'b1;
        victim_d = AB'(w);
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && (age_q[req_idx][w] == AB'(WAYS - 1))) begin
        found    = 1'b1;
        victim_d = AB'(w);
      end
    end
  end

  assign fill_last  = (state_q == FILL) && !iwait && (wcnt_q == WB'(WORDS_PER_BLK - 1));
  assign miss_start = (state_q == IDLE) && (state_d == FILL);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a pending or new flush takes priority over a lookup miss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iflush || flush_pending_q)  state_d = FLUSH;
        else if (imemREN && !hit_any)   state_d = FILL;
      end
      FILL:    if (fill_last) state_d = IDLE;
      FLUSH:   if (fcnt_q == IB'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ihit     = (state_q == IDLE) && !flush_pending_q && imemREN && hit_any;
    imemload = ihit ? data_q[req_idx][hit_way][req_off] : '0;
    iREN     = (state_q == FILL);
    iaddr    = '0;
    if (iREN)
      iaddr = (32'(miss_tag_q) << (2 + OBITS + IB)) |
              (32'(miss_idx_q) << (2 + OBITS)) |
              (32'(wcnt_q) << 2);
    flushing = (state_q == FLUSH);
  end

  // Miss register, fill/flush counters and deferred flush request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      miss_tag_q      <= '0;
      miss_idx_q      <= '0;
      victim_q        <= '0;
      wcnt_q          <= '0;
      fcnt_q          <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      if (miss_start) begin
        miss_tag_q <= req_tag;
        miss_idx_q <= req_idx;
        victim_q   <= victim_d;
      end
      if ((state_q == FILL) && !iwait)
        wcnt_q <= fill_last ? '0 : wcnt_q + WB'(1);
      if ((state_q == FILL) && iflush)
        flush_pending_q <= 1'b1;
      else if ((state_q == IDLE) && (state_d == FLUSH))
        flush_pending_q <= 1'b0;
      if (state_q == FLUSH)
        fcnt_q <= (fcnt_q == IB'(SETS - 1)) ? '0 : fcnt_q + IB'(1);
    end
  end

  // A way becomes most-recent on a hit or when its fill completes; both cannot coincide.
  always_comb begin
    touch_en  = ihit || fill_last;
    touch_set = ihit ? req_idx : miss_idx_q;
    touch_way = ihit ? hit_way : victim_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned s = 0; s < SETS; s++)
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AB'(w);
        end
    end else if (state_q == FLUSH) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid_q[fcnt_q][w] <= 1'b0;
        age_q[fcnt_q][w]   <= AB'(w);
      end
    end else begin
      if (fill_last)
        valid_q[miss_idx_q][victim_q] <= 1'b1;
      if (touch_en) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (AB'(w) == touch_way)
            age_q[touch_set][w] <= '0;
          else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
            age_q[touch_set][w] <= age_q[touch_set][w] + AB'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && (state_q == FILL) && !iwait) begin
      data_q[miss_idx_q][victim_q][wcnt_q] <= iload;
      if (fill_last)
        tag_q[miss_idx_q][victim_q] <= miss_tag_q;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ihit)       hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
